// File: rtl/byte_packer_1_to_4.sv
// byte_packer_1_to_4
//
// Packs a stream of bytes into 32-bit words. Each accepted byte is routed
// into one of four byte lanes selected by a 2-bit lane counter. A word is
// emitted when four bytes have been collected, or earlier on flush (partial
// word, only filled lanes flagged in byte_en). Unfilled lanes read 0.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous, active-high reset (priority over everything)
//   in_byte    byte from the upstream source
//   in_valid   in_byte is valid this cycle
//   in_ready   packer can accept a byte this cycle (decoded from state only)
//   flush      emit a partially filled word
//   word_out   packed word (registered)
//   byte_en    one bit per filled lane; bit k covers word_out[8k+7:8k]
//   out_valid  word_out/byte_en are valid (registered)
//   out_ready  downstream accepts the word this cycle
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on that interface. The byte side transfers only while filling; the
// word side only while holding. Once out_valid is raised, word_out and
// byte_en stay stable until the word transfer.
//
// LANE_ORDER = 0: first byte goes to word_out[7:0]; 1: first byte goes to
// word_out[31:24].

module byte_packer_1_to_4 #(
  parameter int LANE_ORDER = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic [3:0]  byte_en,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic [31:0] word_d;
  logic [3:0]  be_d;
  logic        valid_d;
  logic [1:0]  lane;
  logic        byte_xfer;
  logic        word_xfer;

  // in_ready depends on the current state only, never on in_valid.
  assign in_ready  = (state_q == FILL);
  assign byte_xfer = in_valid && in_ready;
  assign word_xfer = out_valid && out_ready;

  // Lane chosen by the counter, mirrored for big-endian lane order.
  assign lane = (LANE_ORDER != 0) ? (2'd3 - cnt_q) : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_out;
    be_d    = byte_en;
    unique case (state_q)
      FILL: begin
        if (byte_xfer) begin
          word_d[{lane, 3'b000} +: 8] = in_byte;
          be_d[lane]                  = 1'b1;
          cnt_d                       = cnt_q + 2'd1;
          // Fourth byte, or a flush alongside a byte: store then emit.
          if (cnt_q == 2'd3 || flush) begin
            state_d = HOLD;
          end
        end else if (flush && cnt_q != 2'd0) begin
          // Flush with nothing collected is ignored: no empty words.
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (word_xfer) begin
          state_d = FILL;
          cnt_d   = 2'd0;
          word_d  = 32'h0;
          be_d    = 4'b0000;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= 2'd0;
      word_out  <= 32'h0;
      byte_en   <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_out  <= word_d;
      byte_en   <= be_d;
      out_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_byte_packer_1_to_4.sv
// Bench for byte_packer_1_to_4. Two instances (LANE_ORDER 0 and 1) share
// all inputs; a queue-based model of collected bytes predicts both.

module tb_byte_packer_1_to_4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        flush;
  logic        out_ready;

  logic        in_ready0, in_ready1;
  logic [31:0] word0, word1;
  logic [3:0]  be0, be1;
  logic        out_valid0, out_valid1;

  byte_packer_1_to_4 #(.LANE_ORDER(0)) dut0 (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready0), .flush(flush), .word_out(word0),
    .byte_en(be0), .out_valid(out_valid0), .out_ready(out_ready)
  );

  byte_packer_1_to_4 #(.LANE_ORDER(1)) dut1 (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready1), .flush(flush), .word_out(word1),
    .byte_en(be1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_q holds the bytes of the word being collected, oldest first.
  logic [7:0] m_q[$];
  bit         m_hold = 1'b0;

  function automatic logic [31:0] exp_word(input int order);
    logic [31:0] w;
    int lane;
    w = 32'h0;
    for (int i = 0; i < m_q.size(); i++) begin
      lane = (order != 0) ? 3 - i : i;
      w[lane*8 +: 8] = m_q[i];
    end
    return w;
  endfunction

  function automatic logic [3:0] exp_be(input int order);
    logic [3:0] b;
    b = 4'b0000;
    for (int i = 0; i < m_q.size(); i++) begin
      if (order != 0) b[3 - i] = 1'b1;
      else            b[i]     = 1'b1;
    end
    return b;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_q.push_back(in_byte);
        if (m_q.size() == 4 || flush) m_hold = 1'b1;
      end else if (flush && m_q.size() > 0) begin
        m_hold = 1'b1;
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
      m_q.delete();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready0",  {31'd0, in_ready0},  {31'd0, !m_hold});
      chk("in_ready1",  {31'd0, in_ready1},  {31'd0, !m_hold});
      chk("out_valid0", {31'd0, out_valid0}, {31'd0, m_hold});
      chk("out_valid1", {31'd0, out_valid1}, {31'd0, m_hold});
      if (m_hold) begin
        chk("word0", word0, exp_word(0));
        chk("word1", word1, exp_word(1));
        chk("be0", {28'd0, be0}, {28'd0, exp_be(0)});
        chk("be1", {28'd0, be1}, {28'd0, exp_be(1)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [7:0] b, input logic f, input logic r);
    in_valid  = v;
    in_byte   = b;
    flush     = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) drive(1'b1, 8'h99, 1'b1, 1'b1);
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid0}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready0},  32'd1);
    chk({tag, "_word"},  word0,               32'h0);
    chk({tag, "_be"},    {28'd0, be0},        32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; in_byte = 8'h00; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(2);
    check_en = 1'b1;
    check_reset_state("rst0");

    // Full word, little-endian and big-endian views.
    drive(1, 8'h11, 0, 1);
    drive(1, 8'h22, 0, 1);
    drive(1, 8'h33, 0, 1);
    drive(1, 8'h44, 0, 1);
    chk("full_valid", {31'd0, out_valid0}, 32'd1);
    chk("full_word0", word0, 32'h44332211);
    chk("full_word1", word1, 32'h11223344);
    chk("full_be0", {28'd0, be0}, 32'hF);
    drive(0, 8'h00, 0, 1);
    chk("full_back_fill", {31'd0, in_ready0}, 32'd1);
    chk("full_cleared", word0, 32'h0);

    // Backpressure with EE waiting.
    drive(1, 8'hAA, 0, 0);
    drive(1, 8'hBB, 0, 0);
    drive(1, 8'hCC, 0, 0);
    drive(1, 8'hDD, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'hEE, 0, 0);
      chk("bp_ready", {31'd0, in_ready0}, 32'd0);
      chk("bp_word", word0, 32'hDDCCBBAA);
    end
    drive(1, 8'hEE, 0, 1);   // word handshake; EE not taken here
    drive(1, 8'hEE, 0, 1);   // EE accepted into lane 0
    drive(0, 8'h00, 1, 0);   // flush alone
    chk("ee_word0", word0, 32'h000000EE);
    chk("ee_be0", {28'd0, be0}, 32'h1);
    drive(0, 8'h00, 0, 1);

    // Partial flush, then flush with empty counter.
    drive(1, 8'h01, 0, 1);
    drive(1, 8'h02, 0, 1);
    drive(0, 8'h00, 1, 0);
    chk("pf_word0", word0, 32'h00000201);
    chk("pf_be0", {28'd0, be0}, 32'h3);
    chk("pf_be1", {28'd0, be1}, 32'hC);
    drive(0, 8'h00, 0, 1);
    drive(0, 8'h00, 1, 1);
    chk("empty_flush", {31'd0, out_valid0}, 32'd0);

    // Flush together with a byte.
    drive(1, 8'h5A, 1, 0);
    chk("fb_word1", word1, 32'h5A000000);
    chk("fb_be1", {28'd0, be1}, 32'h8);
    chk("fb_word0", word0, 32'h0000005A);
    drive(0, 8'h00, 0, 1);

    // Flush together with the fourth byte.
    drive(1, 8'h01, 0, 1);
    drive(1, 8'h02, 0, 1);
    drive(1, 8'h03, 0, 1);
    drive(1, 8'h04, 1, 0);
    chk("f4_word0", word0, 32'h04030201);
    chk("f4_be0", {28'd0, be0}, 32'hF);
    drive(0, 8'h00, 0, 1);

    // Reset mid-operation.
    drive(1, 8'hA1, 0, 1);
    drive(1, 8'hA2, 0, 1);
    drive(1, 8'hA3, 0, 1);
    do_reset(1);
    check_reset_state("rst1");
    drive(1, 8'h10, 0, 0);
    drive(1, 8'h20, 0, 0);
    drive(1, 8'h30, 0, 0);
    drive(1, 8'h40, 0, 0);
    chk("rst_word0", word0, 32'h40302010);
    drive(0, 8'h00, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else begin
        drive(($urandom_range(0, 3) != 0),
              8'($urandom_range(0, 255)),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 1) == 1));
      end
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
